// File: rtl/proc_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// proc_ctrl_pkg
//   Shared constants and state encoding for the pipeline control logic.
//   No ports.
// ---------------------------------------------------------------------------
package proc_ctrl_pkg;

    parameter int REG_ADDR_LEN = 5;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        LDSTALL = 2'd1,
        MEMWAIT = 2'd2
    } state_t;

endpackage

// File: rtl/sat_counter.sv
// ---------------------------------------------------------------------------
// sat_counter
//   Up-counter with synchronous clear that holds at all-ones.
//   Ports:
//     i_clk    clock
//     i_reset  synchronous active-high reset (zeroes the count)
//     i_clr    synchronous clear (zeroes the count)
//     i_inc    increment request
//     o_cnt    current count
// ---------------------------------------------------------------------------
module sat_counter #(
    parameter int W = 8
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic         i_clr,
    input  logic         i_inc,
    output logic [W-1:0] o_cnt
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (i_reset || i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && (r_cnt != '1)) begin
            r_cnt <= r_cnt + W'(1);
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipeline_hazard_ctrl
//   Central sequencer for the 5-stage pipeline: PC / pipeline-register
//   enables and flushes, load-use stall, EX-resolved redirects, memory freeze,
//   plus saturating statistics and a sticky memory-timeout flag.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   RUN   | normal flow (also the state after a redirect)
//   LDSTALL | one-cycle load-use bubble inserted into ID/EX
//   MEMWAIT | whole pipeline frozen waiting on data memory
//
//   Ports:
//     i_clk, i_reset          clock, synchronous active-high reset
//     i_id_rs/i_id_rt         source indices of the instr in ID
//     i_id_uses_rs/_rt        ID instr reads rs / rt
//     i_ex_mem_read, i_ex_dst load in EX and its destination
//     i_ex_br_taken, i_ex_jmp redirect resolved in EX
//     i_mem_req, i_mem_ready  MEM stage access and data memory completion
//     o_pc_en, o_pregN_en     PC and pipeReg1..4 load enables
//     o_preg1/2_flush         NOP / bubble insertion into pipeReg1 / pipeReg2
//     o_state                 registered state (RUN/LDSTALL/MEMWAIT)
//     o_stall_cycles          saturating count of cycles with pc_en = 0
//     o_redirects             saturating count of redirects taken
//     o_mem_err               sticky memory-timeout flag
// ---------------------------------------------------------------------------
module pipeline_hazard_ctrl
    import proc_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15,
    parameter int STALL_CW    = 16,
    parameter int REDIR_CW    = 8
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic [REG_ADDR_LEN-1:0] i_id_rs,
    input  logic [REG_ADDR_LEN-1:0] i_id_rt,
    input  logic                    i_id_uses_rs,
    input  logic                    i_id_uses_rt,
    input  logic                    i_ex_mem_read,
    input  logic [REG_ADDR_LEN-1:0] i_ex_dst,
    input  logic                    i_ex_br_taken,
    input  logic                    i_ex_jmp,
    input  logic                    i_mem_req,
    input  logic                    i_mem_ready,
    output logic                    o_pc_en,
    output logic                    o_preg1_en,
    output logic                    o_preg2_en,
    output logic                    o_preg3_en,
    output logic                    o_preg4_en,
    output logic                    o_preg1_flush,
    output logic                    o_preg2_flush,
    output logic [1:0]              o_state,
    output logic [STALL_CW-1:0]     o_stall_cycles,
    output logic [REDIR_CW-1:0]     o_redirects,
    output logic                    o_mem_err
);

    localparam int WAIT_CW = $clog2(MEM_TIMEOUT + 1);

    state_t               r_state;
    state_t               w_state_nxt;
    logic                 r_mem_err;
    logic                 w_freeze;
    logic                 w_redirect;
    logic                 w_lu;
    logic                 w_stall_inc;
    logic                 w_redir_inc;
    logic                 w_timeout;
    logic [WAIT_CW-1:0]   w_wait_cnt;

    assign w_freeze   = i_mem_req & ~i_mem_ready;
    assign w_redirect = i_ex_br_taken | i_ex_jmp;
    assign w_lu       = i_ex_mem_read & (i_ex_dst != '0) &
                        ((i_id_uses_rs & (i_id_rs == i_ex_dst)) |
                         (i_id_uses_rt & (i_id_rt == i_ex_dst)));

    always_comb begin
        o_pc_en       = 1'b1;
        o_preg1_en    = 1'b1;
        o_preg2_en    = 1'b1;
        o_preg3_en    = 1'b1;
        o_preg4_en    = 1'b1;
        o_preg1_flush = 1'b0;
        o_preg2_flush = 1'b0;
        w_state_nxt   = RUN;
        if (i_reset) begin
            o_pc_en       = 1'b0;
            o_preg1_en    = 1'b0;
            o_preg2_en    = 1'b0;
            o_preg3_en    = 1'b0;
            o_preg4_en    = 1'b0;
            o_preg1_flush = 1'b1;
            o_preg2_flush = 1'b1;
        end else if (w_freeze) begin
            o_pc_en     = 1'b0;
            o_preg1_en  = 1'b0;
            o_preg2_en  = 1'b0;
            o_preg3_en  = 1'b0;
            o_preg4_en  = 1'b0;
            w_state_nxt = MEMWAIT;
        end else if (w_redirect) begin
            // ID and IF hold wrong-path instructions: squash both slots.
            o_preg1_flush = 1'b1;
            o_preg2_flush = 1'b1;
        end else if (w_lu) begin
            o_pc_en       = 1'b0;
            o_preg1_en    = 1'b0;
            o_preg2_flush = 1'b1;
            w_state_nxt   = LDSTALL;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    assign w_stall_inc = ~i_reset & ~o_pc_en;
    assign w_redir_inc = ~i_reset & ~w_freeze & w_redirect;

    sat_counter #(.W(STALL_CW)) u_stall_cnt (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_clr   (1'b0),
        .i_inc   (w_stall_inc),
        .o_cnt   (o_stall_cycles)
    );

    sat_counter #(.W(REDIR_CW)) u_redir_cnt (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_clr   (1'b0),
        .i_inc   (w_redir_inc),
        .o_cnt   (o_redirects)
    );

    sat_counter #(.W(WAIT_CW)) u_wait_cnt (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_clr   (~w_freeze),
        .i_inc   (w_freeze),
        .o_cnt   (w_wait_cnt)
    );

    // Flag in the same edge that takes wait_cnt to MEM_TIMEOUT; the >= also
    // covers a counter already saturated at the timeout value.
    assign w_timeout = w_freeze & (w_wait_cnt >= WAIT_CW'(MEM_TIMEOUT - 1));

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_mem_err <= 1'b0;
        end else if (w_timeout) begin
            r_mem_err <= 1'b1;
        end
    end

    assign o_state   = r_state;
    assign o_mem_err = r_mem_err;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
module tb_pipeline_hazard_ctrl;

    localparam int STALL_MAX = 65535;
    localparam int REDIR_MAX = 255;
    localparam int TIMEOUT   = 15;

    // pipeline actions in priority order
    localparam int A_RST = 0, A_FRZ = 1, A_RED = 2, A_LU = 3, A_RUN = 4;

    // {pc, p1, p2, p3, p4, flush1, flush2} for each action
    logic [6:0] ctrl_tbl [5];
    int         nxt_tbl  [5];

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] id_rs, id_rt, ex_dst;
    logic       id_uses_rs, id_uses_rt, ex_mem_read, ex_br_taken, ex_jmp;
    logic       mem_req, mem_ready;
    logic       pc_en, preg1_en, preg2_en, preg3_en, preg4_en;
    logic       preg1_flush, preg2_flush;
    logic [1:0] state;
    logic [15:0] stall_cycles;
    logic [7:0] redirects;
    logic       mem_err;

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 0;

    int m_state, m_stall, m_redir, m_wait;
    bit m_err;

    pipeline_hazard_ctrl dut (
        .i_clk          (clk),
        .i_reset        (reset),
        .i_id_rs        (id_rs),
        .i_id_rt        (id_rt),
        .i_id_uses_rs   (id_uses_rs),
        .i_id_uses_rt   (id_uses_rt),
        .i_ex_mem_read  (ex_mem_read),
        .i_ex_dst       (ex_dst),
        .i_ex_br_taken  (ex_br_taken),
        .i_ex_jmp       (ex_jmp),
        .i_mem_req      (mem_req),
        .i_mem_ready    (mem_ready),
        .o_pc_en        (pc_en),
        .o_preg1_en     (preg1_en),
        .o_preg2_en     (preg2_en),
        .o_preg3_en     (preg3_en),
        .o_preg4_en     (preg4_en),
        .o_preg1_flush  (preg1_flush),
        .o_preg2_flush  (preg2_flush),
        .o_state        (state),
        .o_stall_cycles (stall_cycles),
        .o_redirects    (redirects),
        .o_mem_err      (mem_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit load_use();
        logic [4:0] src [2];
        bit         used [2];
        src[0] = id_rs; used[0] = id_uses_rs;
        src[1] = id_rt; used[1] = id_uses_rt;
        if (!ex_mem_read || ex_dst == 5'd0) return 1'b0;
        for (int k = 0; k < 2; k++)
            if (used[k] && src[k] == ex_dst) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int classify();
        if (reset === 1'b1)                 return A_RST;
        if (mem_req && !mem_ready)          return A_FRZ;
        if (ex_br_taken || ex_jmp)          return A_RED;
        if (load_use())                     return A_LU;
        return A_RUN;
    endfunction

    function automatic int sat_inc(input int v, input int mx);
        return (v >= mx) ? mx : v + 1;
    endfunction

    // reference model: registered view advances on every posedge
    always @(posedge clk) begin
        int a;
        a = classify();
        if (a == A_RST) begin
            m_state = 0; m_stall = 0; m_redir = 0; m_wait = 0; m_err = 0;
        end else begin
            m_state = nxt_tbl[a];
            if (ctrl_tbl[a][6] == 1'b0) m_stall = sat_inc(m_stall, STALL_MAX);
            if (a == A_RED) m_redir = sat_inc(m_redir, REDIR_MAX);
            if (a == A_FRZ) begin
                m_wait++;
                if (m_wait >= TIMEOUT) m_err = 1;
            end else begin
                m_wait = 0;
            end
        end
    end

    // compare process: combinational outputs and registered outputs
    always @(negedge clk) begin
        if (chk_en) begin
            chk("ctrl", int'({pc_en, preg1_en, preg2_en, preg3_en, preg4_en,
                              preg1_flush, preg2_flush}), int'(ctrl_tbl[classify()]));
            chk("state", int'(state), m_state);
            chk("stall_cycles", int'(stall_cycles), m_stall);
            chk("redirects", int'(redirects), m_redir);
            chk("mem_err", int'(mem_err), int'(m_err));
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        reset = 0; id_rs = 0; id_rt = 0; id_uses_rs = 0; id_uses_rt = 0;
        ex_mem_read = 0; ex_dst = 0; ex_br_taken = 0; ex_jmp = 0;
        mem_req = 0; mem_ready = 1;
    endtask

    task automatic do_reset();
        next_cycle(); idle(); reset = 1;
        next_cycle(); idle();
    endtask

    task automatic rand_inputs(input int p_rst, input int p_req, input int p_rdy,
                               input int p_br);
        reset       = ($urandom_range(99) < p_rst);
        id_rs       = ($urandom_range(3) == 0) ? 5'($urandom) : 5'($urandom_range(3));
        id_rt       = 5'($urandom_range(3));
        id_uses_rs  = $urandom_range(1);
        id_uses_rt  = $urandom_range(1);
        ex_mem_read = ($urandom_range(99) < 45);
        ex_dst      = 5'($urandom_range(3));
        ex_br_taken = ($urandom_range(99) < p_br);
        ex_jmp      = ($urandom_range(99) < p_br / 3);
        mem_req     = ($urandom_range(99) < p_req);
        mem_ready   = ($urandom_range(99) < p_rdy);
    endtask

    initial begin
        ctrl_tbl = '{7'b0000011, 7'b0000000, 7'b1111111, 7'b0011101, 7'b1111100};
        nxt_tbl  = '{0, 2, 0, 1, 0};
        m_state = 0; m_stall = 0; m_redir = 0; m_wait = 0; m_err = 0;
        idle();
        reset = 1;
        #2;
        chk("rst_flush", int'({preg1_flush, preg2_flush}), 3);
        chk("rst_pc_en", int'(pc_en), 0);
        next_cycle(); next_cycle();
        chk_en = 1;
        idle();
        #2;
        chk("rst_state", int'(state), 0);
        chk("rst_stall", int'(stall_cycles), 0);
        chk("rst_redir", int'(redirects), 0);
        chk("rst_err", int'(mem_err), 0);

        // T1 load-use
        next_cycle();
        ex_mem_read = 1; ex_dst = 5'd3; id_rs = 5'd3; id_uses_rs = 1;
        #2;
        chk("t1_pc_en", int'(pc_en), 0);
        chk("t1_preg1_en", int'(preg1_en), 0);
        chk("t1_preg2_flush", int'(preg2_flush), 1);
        next_cycle(); idle();
        #2;
        chk("t1_state_ld", int'(state), 1);
        chk("t1_pc_en_after", int'(pc_en), 1);
        chk("t1_stall", int'(stall_cycles), 1);
        next_cycle();
        #2;
        chk("t1_state_run", int'(state), 0);

        // T2 load to $0
        ex_mem_read = 1; ex_dst = 5'd0; id_rs = 5'd0; id_uses_rs = 1;
        #2;
        chk("t2_pc_en", int'(pc_en), 1);
        next_cycle(); idle();
        #2;
        chk("t2_state", int'(state), 0);
        chk("t2_stall", int'(stall_cycles), 1);

        // T3 redirect beats load-use
        next_cycle();
        ex_br_taken = 1; ex_mem_read = 1; ex_dst = 5'd3; id_rs = 5'd3; id_uses_rs = 1;
        #2;
        chk("t3_flushes", int'({preg1_flush, preg2_flush}), 3);
        chk("t3_pc_en", int'(pc_en), 1);
        next_cycle(); idle();
        #2;
        chk("t3_redir", int'(redirects), 1);
        chk("t3_stall", int'(stall_cycles), 1);

        // T4 three-cycle memory wait
        do_reset();
        for (int i = 0; i < 3; i++) begin
            mem_req = 1; mem_ready = 0;
            #2;
            chk("t4_enables", int'({pc_en, preg1_en, preg2_en, preg3_en, preg4_en}), 0);
            next_cycle();
        end
        mem_req = 1; mem_ready = 1;
        #2;
        chk("t4_state", int'(state), 2);
        chk("t4_stall", int'(stall_cycles), 3);
        chk("t4_release", int'({pc_en, preg1_en, preg2_en, preg3_en, preg4_en}), 31);
        next_cycle(); idle();
        #2;
        chk("t4_state_run", int'(state), 0);

        // T5 memory timeout
        do_reset();
        for (int i = 0; i < 16; i++) begin
            mem_req = 1; mem_ready = 0;
            #2;
            if (i == 14) chk("t5_err_pre", int'(mem_err), 0);
            if (i == 15) chk("t5_err_set", int'(mem_err), 1);
            next_cycle();
        end
        mem_ready = 1;
        next_cycle(); idle();
        #2;
        chk("t5_state", int'(state), 0);
        chk("t5_err_sticky", int'(mem_err), 1);

        // T6 reset in MEMWAIT
        do_reset();
        for (int i = 0; i < 7; i++) begin
            mem_req = 1; mem_ready = 0;
            next_cycle();
        end
        mem_req = 1; mem_ready = 0;
        #2;
        chk("t6_stall7", int'(stall_cycles), 7);
        reset = 1;
        #1;
        chk("t6_flushes", int'({preg1_flush, preg2_flush}), 3);
        next_cycle(); idle();
        #2;
        chk("t6_state", int'(state), 0);
        chk("t6_stall", int'(stall_cycles), 0);
        chk("t6_err", int'(mem_err), 0);

        // randomized phases, checked by the model every cycle
        for (int i = 0; i < 800; i++) begin next_cycle(); rand_inputs(2, 30, 70, 15); end
        for (int i = 0; i < 600; i++) begin next_cycle(); rand_inputs(1, 60, 8, 10); end
        for (int i = 0; i < 400; i++) begin next_cycle(); rand_inputs(0, 10, 90, 90); end
        next_cycle(); idle();
        chk("rand_redir_sat", int'(redirects), REDIR_MAX);
        for (int i = 0; i < 400; i++) begin next_cycle(); rand_inputs(3, 40, 50, 20); end

        next_cycle(); idle();
        next_cycle();
        chk_en = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
